alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Decodes a 6502 ALU-class opcode and drives the 16-bit ALU control word OP, one step per clock.
//  Sits between instruction fetch/decode and the ALU; it is the OP-word producer for the ALU.
//  Multi-step instructions (CMP, INC, DEC) pre-set carry and, for INC/DEC, restore the caller's C.
// PARAMETERS
//  OP_W       16  ALU control word width; fixed at 16.
//  C_RESTORE  1   1: INC/DEC add a step that restores C. 0: INC/DEC leave C modified (2 steps).
// PORTS
//  CLK      in   1     system clock.
//  RESET    in   1     synchronous, active-high reset.
//  START    in   1     request; accepted only when BUSY=0.
//  OPCODE   in   8     6502 opcode, sampled on accept.
//  C_IN     in   1     current ALU carry flag, sampled on accept.
//  OP       out  16    registered ALU control word; 16'h0000 = NOP (all flags hold).
//  B_FF     out  1     datapath must force ALU B=8'hFF (shift pass-through via AND).
//  RES_WE   out  1     write ALU result Y to destination during this step.
//  BUSY     out  1     high in DEC and STEP states.
//  DONE     out  1     one-cycle pulse in FIN.
//  ILLEGAL  out  1     with DONE: opcode not ALU-class, no OP issued.
// BEHAVIOUR
//  Reset: state IDLE; OP=0, B_FF=0, RES_WE=0, BUSY=0, DONE=0, ILLEGAL=0. Reset mid-op aborts
//   with no restore step; the next cycle shows reset values.
//  FSM: IDLE -> DEC -> STEP1 [-> STEP2 [-> STEP3]] -> FIN -> IDLE. Illegal: DEC -> FIN.
//  Accept in cycle n (START & ~BUSY, in IDLE or FIN). n+1 DEC (OP=0). First OP step at n+2.
//   DONE in the cycle after the last step. START in FIN is accepted (FIN -> DEC).
//   START while BUSY is ignored and not queued.
//  OP fields: [1:0] ADD,BOP or logic op; [2] logic sel; [5:3] shift (001 ASL,011 LSR,100 ROL,101 ROR);
//   [8] C load, [7:6] C src (00 adder,01 shifter,10 zero,11 one); [11] V load, [10:9] V src
//   (00 adder,10 zero); [13:12], [15:14] Z, N (00 hold, 01 from result).
//  Decode: cc=01, aaa: 000 ORA 5005; 001 AND 5004; 010 EOR 5006; 011 ADC 5903; 111 SBC 5902.
//   Each is 1 step with RES_WE=1.
//   110 CMP: 2 steps, 01C0 then 5102; RES_WE=0 on both steps.
//   100 and 101 (STA, LDA) are ILLEGAL.
//  cc=10 shifts, aaa 000-011, bbb in {001,010,011,101,111}: B_FF=1, RES_WE=1, 1 step.
//   ASL 514C, ROL 5164, LSR 515C, ROR 516C.
//  cc=10 aaa=110 DEC / 111 INC, bbb in {001,011,101,111}:
//   DEC: 0180, then 5000 (RES_WE=1), then restore.
//   INC: 01C0, then 5001 (RES_WE=1), then restore.
//   Restore step is 01C0 if the latched C_IN=1, else 0180. Omitted when C_RESTORE=0.
//  $18 CLC 0180, $38 SEC 01C0, $B8 CLV 0C00: 1 step, RES_WE=0. All other opcodes ILLEGAL.
//  B_FF/RES_WE are valid only with their step's OP, and are 0 in IDLE, DEC and FIN. OP=0 outside steps.
//  Opcode and C_IN are latched at accept; later changes on these inputs do not affect the sequence.
// STRUCTURE
//  alu_ctrl_pkg: OP field localparams, C/V/Z/N source codes, the named OP constants above, state encoding.
//  Sub-module alu_op_rom: combinational map opcode, step index, saved C -> {OP, B_FF, RES_WE, last, illegal}.
//  The top level holds the FSM, latches and output registers.
// TESTING
//  ADC: OPCODE=$69 accepted at n -> n+2 OP=5903, RES_WE=1 -> n+3 DONE=1, BUSY=0, OP=0.
//  CMP: $C9 -> n+2 OP=01C0 (RES_WE=0) -> n+3 OP=5102 (RES_WE=0) -> n+4 DONE.
//  INC, C_IN=0: $E6 -> 01C0, 5001 (RES_WE=1), 0180 -> DONE at n+5.
//   Same with C_RESTORE=0 -> DONE at n+4, no 0180 step.
//  LSR A: $4A -> n+2 OP=515C, B_FF=1, RES_WE=1. DEC $C6 with C_IN=1 -> third step OP=01C0.
//  Illegal: $A9 -> n+2 DONE=1, ILLEGAL=1; OP stays 0 throughout.
//  Control: START while BUSY ignored; START in FIN cycle -> DEC next cycle.
//   RESET during INC step 2 -> next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//  Shared definitions for the ALU OP-word sequencer: OP field codes, a
//  helper that packs the 16-bit OP word, the named OP constants for every
//  supported step, and the sequencer state encoding.
//
//  OP word layout (MSB..LSB):
//    [15:14] N src  [13:12] Z src  [11] V load  [10:9] V src
//    [8] C load     [7:6] C src    [5:3] shift  [2] logic sel  [1:0] fn
package alu_ctrl_pkg;

  localparam int ALU_OP_W = 16;

  // Z / N sources
  localparam logic [1:0] ZN_HOLD   = 2'b00;
  localparam logic [1:0] ZN_RESULT = 2'b01;

  // Carry sources
  localparam logic [1:0] C_SRC_ADDER = 2'b00;
  localparam logic [1:0] C_SRC_SHIFT = 2'b01;
  localparam logic [1:0] C_SRC_ZERO  = 2'b10;
  localparam logic [1:0] C_SRC_ONE   = 2'b11;

  // Overflow sources
  localparam logic [1:0] V_SRC_ADDER = 2'b00;
  localparam logic [1:0] V_SRC_ZERO  = 2'b10;

  // Shifter modes
  localparam logic [2:0] SH_NONE = 3'b000;
  localparam logic [2:0] SH_ASL  = 3'b001;
  localparam logic [2:0] SH_LSR  = 3'b011;
  localparam logic [2:0] SH_ROL  = 3'b100;
  localparam logic [2:0] SH_ROR  = 3'b101;

  // fn field with logic sel = 1
  localparam logic [1:0] LOP_AND = 2'b00;
  localparam logic [1:0] LOP_ORA = 2'b01;
  localparam logic [1:0] LOP_EOR = 2'b10;

  // fn field with logic sel = 0 (adder; carry-in is the current C flag)
  localparam logic [1:0] FN_NONE         = 2'b00;
  localparam logic [1:0] ARITH_A_PLUS_FF = 2'b00;  // A + FF + C  (DEC with C=0)
  localparam logic [1:0] ARITH_A_PLUS_0  = 2'b01;  // A + 0  + C  (INC with C=1)
  localparam logic [1:0] ARITH_A_MINUS_B = 2'b10;  // A + ~B + C
  localparam logic [1:0] ARITH_A_PLUS_B  = 2'b11;  // A + B  + C

  function automatic logic [ALU_OP_W-1:0] op_word(
    input logic [1:0] n_src,
    input logic [1:0] z_src,
    input logic       v_ld,
    input logic [1:0] v_src,
    input logic       c_ld,
    input logic [1:0] c_src,
    input logic [2:0] shift,
    input logic       lsel,
    input logic [1:0] fn
  );
    return {n_src, z_src, v_ld, v_src, c_ld, c_src, shift, lsel, fn};
  endfunction

  localparam logic [ALU_OP_W-1:0] OP_NOP = '0;
  localparam logic [ALU_OP_W-1:0] OP_ORA =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b0, C_SRC_ADDER, SH_NONE, 1'b1, LOP_ORA);
  localparam logic [ALU_OP_W-1:0] OP_AND =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b0, C_SRC_ADDER, SH_NONE, 1'b1, LOP_AND);
  localparam logic [ALU_OP_W-1:0] OP_EOR =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b0, C_SRC_ADDER, SH_NONE, 1'b1, LOP_EOR);
  localparam logic [ALU_OP_W-1:0] OP_ADC =
    op_word(ZN_RESULT, ZN_RESULT, 1'b1, V_SRC_ADDER, 1'b1, C_SRC_ADDER, SH_NONE, 1'b0, ARITH_A_PLUS_B);
  localparam logic [ALU_OP_W-1:0] OP_SBC =
    op_word(ZN_RESULT, ZN_RESULT, 1'b1, V_SRC_ADDER, 1'b1, C_SRC_ADDER, SH_NONE, 1'b0, ARITH_A_MINUS_B);
  localparam logic [ALU_OP_W-1:0] OP_CMP =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b1, C_SRC_ADDER, SH_NONE, 1'b0, ARITH_A_MINUS_B);
  localparam logic [ALU_OP_W-1:0] OP_DEC =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b0, C_SRC_ADDER, SH_NONE, 1'b0, ARITH_A_PLUS_FF);
  localparam logic [ALU_OP_W-1:0] OP_INC =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b0, C_SRC_ADDER, SH_NONE, 1'b0, ARITH_A_PLUS_0);
  localparam logic [ALU_OP_W-1:0] OP_CLC =
    op_word(ZN_HOLD, ZN_HOLD, 1'b0, V_SRC_ADDER, 1'b1, C_SRC_ZERO, SH_NONE, 1'b0, FN_NONE);
  localparam logic [ALU_OP_W-1:0] OP_SEC =
    op_word(ZN_HOLD, ZN_HOLD, 1'b0, V_SRC_ADDER, 1'b1, C_SRC_ONE, SH_NONE, 1'b0, FN_NONE);
  localparam logic [ALU_OP_W-1:0] OP_CLV =
    op_word(ZN_HOLD, ZN_HOLD, 1'b1, V_SRC_ZERO, 1'b0, C_SRC_ADDER, SH_NONE, 1'b0, FN_NONE);
  // Shifts pass A through the shifter and AND it with B=FF.
  localparam logic [ALU_OP_W-1:0] OP_ASL =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b1, C_SRC_SHIFT, SH_ASL, 1'b1, LOP_AND);
  localparam logic [ALU_OP_W-1:0] OP_ROL =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b1, C_SRC_SHIFT, SH_ROL, 1'b1, LOP_AND);
  localparam logic [ALU_OP_W-1:0] OP_LSR =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b1, C_SRC_SHIFT, SH_LSR, 1'b1, LOP_AND);
  localparam logic [ALU_OP_W-1:0] OP_ROR =
    op_word(ZN_RESULT, ZN_RESULT, 1'b0, V_SRC_ADDER, 1'b1, C_SRC_SHIFT, SH_ROR, 1'b1, LOP_AND);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_STEP = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_rom.sv
// alu_op_rom
//  Combinational decode of (opcode, step index, saved carry) into the
//  step's ALU control word and side signals.
//  Ports:
//    opcode   in  8   latched 6502 opcode (aaa bbb cc)
//    step     in  2   step index, 0 = first OP step
//    c_saved  in  1   carry flag latched at accept (selects restore step)
//    op       out 16  OP word for this step
//    b_ff     out 1   force ALU B = FF
//    res_we   out 1   write ALU result this step
//    last     out 1   this is the final OP step
//    illegal  out 1   opcode is not ALU-class (independent of step)
module alu_op_rom
  import alu_ctrl_pkg::*;
#(
  parameter bit C_RESTORE = 1'b1
) (
  input  logic [7:0]          opcode,
  input  logic [1:0]          step,
  input  logic                c_saved,
  output logic [ALU_OP_W-1:0] op,
  output logic                b_ff,
  output logic                res_we,
  output logic                last,
  output logic                illegal
);

  logic [2:0] aaa;
  logic [2:0] bbb;
  logic [1:0] cc;

  assign aaa = opcode[7:5];
  assign bbb = opcode[4:2];
  assign cc  = opcode[1:0];

  always_comb begin
    op      = OP_NOP;
    b_ff    = 1'b0;
    res_we  = 1'b0;
    last    = 1'b1;
    illegal = 1'b0;

    if (cc == 2'b01) begin
      case (aaa)
        3'b000: begin op = OP_ORA; res_we = 1'b1; end
        3'b001: begin op = OP_AND; res_we = 1'b1; end
        3'b010: begin op = OP_EOR; res_we = 1'b1; end
        3'b011: begin op = OP_ADC; res_we = 1'b1; end
        3'b111: begin op = OP_SBC; res_we = 1'b1; end
        3'b110: begin
          // CMP: force C=1 so the subtract has no borrow-in, then compare.
          if (step == 2'd0) begin
            op   = OP_SEC;
            last = 1'b0;
          end else begin
            op = OP_CMP;
          end
        end
        default: illegal = 1'b1;  // STA / LDA
      endcase
    end else if (cc == 2'b10 && !aaa[2]) begin
      // Shift addressing modes: A, zp, abs, zp,X, abs,X
      if (bbb[0] || bbb == 3'b010) begin
        b_ff   = 1'b1;
        res_we = 1'b1;
        case (aaa[1:0])
          2'b00:   op = OP_ASL;
          2'b01:   op = OP_ROL;
          2'b10:   op = OP_LSR;
          default: op = OP_ROR;
        endcase
      end else begin
        illegal = 1'b1;
      end
    end else if (cc == 2'b10 && aaa[2:1] == 2'b11) begin
      // DEC (aaa=110) / INC (aaa=111), memory modes only.
      if (bbb[0]) begin
        case (step)
          2'd0: begin
            op   = aaa[0] ? OP_SEC : OP_CLC;
            last = 1'b0;
          end
          2'd1: begin
            op     = aaa[0] ? OP_INC : OP_DEC;
            res_we = 1'b1;
            last   = !C_RESTORE;
          end
          default: op = c_saved ? OP_SEC : OP_CLC;  // put the caller's C back
        endcase
      end else begin
        illegal = 1'b1;
      end
    end else begin
      case (opcode)
        8'h18:   op = OP_CLC;
        8'h38:   op = OP_SEC;
        8'hB8:   op = OP_CLV;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//  Accepts a 6502 ALU-class opcode and issues its ALU control words, one per
//  clock, between decode and the ALU. All outputs are registered.
//  Ports:
//    CLK      in   1   clock
//    RESET    in   1   synchronous active-high reset
//    START    in   1   request, accepted when BUSY=0 (IDLE or FIN)
//    OPCODE   in   8   opcode, latched on accept
//    C_IN     in   1   carry flag, latched on accept
//    OP       out  16  ALU control word (0 = NOP)
//    B_FF     out  1   force ALU B = FF this step
//    RES_WE   out  1   write ALU result this step
//    BUSY     out  1   high in DEC and STEP
//    DONE     out  1   one-cycle pulse in FIN
//    ILLEGAL  out  1   with DONE: opcode rejected, no OP issued
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W      = 16,
  parameter bit C_RESTORE = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [7:0]      OPCODE,
  input  logic            C_IN,
  output logic [OP_W-1:0] OP,
  output logic            B_FF,
  output logic            RES_WE,
  output logic            BUSY,
  output logic            DONE,
  output logic            ILLEGAL
);

  state_e          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [7:0]      opcode_q, opcode_d;
  logic            c_q, c_d;
  logic            last_q, last_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            b_ff_q, b_ff_d;
  logic            res_we_q, res_we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;

  logic [1:0]      rom_step;
  logic [OP_W-1:0] rom_op;
  logic            rom_b_ff;
  logic            rom_res_we;
  logic            rom_last;
  logic            rom_illegal;

  // The ROM is always looked up for the step about to be entered, so the
  // output registers can load its result directly.
  assign rom_step = (state_q == ST_STEP) ? step_q + 2'd1 : 2'd0;

  alu_op_rom #(
    .C_RESTORE(C_RESTORE)
  ) u_rom (
    .opcode (opcode_q),
    .step   (rom_step),
    .c_saved(c_q),
    .op     (rom_op),
    .b_ff   (rom_b_ff),
    .res_we (rom_res_we),
    .last   (rom_last),
    .illegal(rom_illegal)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    opcode_d  = opcode_q;
    c_d       = c_q;
    last_d    = last_q;
    op_d      = '0;
    b_ff_d    = 1'b0;
    res_we_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          state_d  = ST_DEC;
          opcode_d = OPCODE;
          c_d      = C_IN;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEC: begin
        if (rom_illegal) begin
          state_d   = ST_FIN;
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d  = ST_STEP;
          step_d   = 2'd0;
          last_d   = rom_last;
          op_d     = rom_op;
          b_ff_d   = rom_b_ff;
          res_we_d = rom_res_we;
          busy_d   = 1'b1;
        end
      end
      ST_STEP: begin
        if (last_q) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          step_d   = rom_step;
          last_d   = rom_last;
          op_d     = rom_op;
          b_ff_d   = rom_b_ff;
          res_we_d = rom_res_we;
          busy_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      step_q    <= 2'd0;
      opcode_q  <= 8'h00;
      c_q       <= 1'b0;
      last_q    <= 1'b0;
      op_q      <= '0;
      b_ff_q    <= 1'b0;
      res_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      opcode_q  <= opcode_d;
      c_q       <= c_d;
      last_q    <= last_d;
      op_q      <= op_d;
      b_ff_q    <= b_ff_d;
      res_we_q  <= res_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign OP      = op_q;
  assign B_FF    = b_ff_q;
  assign RES_WE  = res_we_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//  Drives two sequencers (C_RESTORE=1 and C_RESTORE=0) with identical input
//  and checks every output cycle against a reference model that lists the
//  expected OP steps per opcode.
module tb_alu_op_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [7:0]  OPCODE;
  logic        C_IN;

  logic [15:0] op_r, op_n;
  logic        bff_r, bff_n, we_r, we_n, busy_r, busy_n, done_r, done_n, ill_r, ill_n;

  int checks = 0;
  int errors = 0;

  // {OP, B_FF, RES_WE, BUSY, DONE, ILLEGAL}
  typedef logic [20:0]       obs_t;
  typedef logic [5:0][20:0]  trace_t;

  alu_op_sequencer #(.OP_W(16), .C_RESTORE(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE), .C_IN(C_IN),
    .OP(op_r), .B_FF(bff_r), .RES_WE(we_r), .BUSY(busy_r), .DONE(done_r), .ILLEGAL(ill_r)
  );

  alu_op_sequencer #(.OP_W(16), .C_RESTORE(1'b0)) dut_nr (
    .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE), .C_IN(C_IN),
    .OP(op_n), .B_FF(bff_n), .RES_WE(we_n), .BUSY(busy_n), .DONE(done_n), .ILLEGAL(ill_n)
  );

  always #5 CLK = ~CLK;

  // Reference: expected outputs for the 6 cycles following the accept cycle.
  function automatic trace_t build(input logic [7:0] opc, input logic c, input logic restore);
    logic [17:0] steps[$];  // {OP, B_FF, RES_WE}
    logic        ill;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [1:0]  g;
    trace_t      tr;
    ill = 1'b0;
    a = opc[7:5];
    b = opc[4:2];
    g = opc[1:0];
    if (opc == 8'h18)      steps.push_back({16'h0180, 2'b00});
    else if (opc == 8'h38) steps.push_back({16'h01C0, 2'b00});
    else if (opc == 8'hB8) steps.push_back({16'h0C00, 2'b00});
    else if (g == 2'b01) begin
      case (a)
        3'd0: steps.push_back({16'h5005, 2'b01});
        3'd1: steps.push_back({16'h5004, 2'b01});
        3'd2: steps.push_back({16'h5006, 2'b01});
        3'd3: steps.push_back({16'h5903, 2'b01});
        3'd7: steps.push_back({16'h5902, 2'b01});
        3'd6: begin
          steps.push_back({16'h01C0, 2'b00});
          steps.push_back({16'h5102, 2'b00});
        end
        default: ill = 1'b1;
      endcase
    end else if (g == 2'b10 && a <= 3'd3 && b != 3'd0 && b != 3'd4 && b != 3'd6) begin
      case (a)
        3'd0:    steps.push_back({16'h514C, 2'b11});
        3'd1:    steps.push_back({16'h5164, 2'b11});
        3'd2:    steps.push_back({16'h515C, 2'b11});
        default: steps.push_back({16'h516C, 2'b11});
      endcase
    end else if (g == 2'b10 && a >= 3'd6 && (b == 3'd1 || b == 3'd3 || b == 3'd5 || b == 3'd7)) begin
      if (a == 3'd7) begin
        steps.push_back({16'h01C0, 2'b00});
        steps.push_back({16'h5001, 2'b01});
      end else begin
        steps.push_back({16'h0180, 2'b00});
        steps.push_back({16'h5000, 2'b01});
      end
      if (restore) steps.push_back({(c ? 16'h01C0 : 16'h0180), 2'b00});
    end else begin
      ill = 1'b1;
    end
    tr = '0;
    tr[0] = {16'h0000, 2'b00, 3'b100};  // DEC cycle
    foreach (steps[i]) tr[i+1] = {steps[i], 3'b100};
    tr[steps.size()+1] = {16'h0000, 2'b00, 2'b01, ill};
    return tr;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input obs_t exp_r, input obs_t exp_n);
    obs_t got_r;
    obs_t got_n;
    @(negedge CLK);
    got_r = {op_r, bff_r, we_r, busy_r, done_r, ill_r};
    got_n = {op_n, bff_n, we_n, busy_n, done_n, ill_n};
    checks++;
    assert (got_r === exp_r) else begin
      errors++;
      $error("FAIL %s (restore) got=%h want=%h", tag, got_r, exp_r);
    end
    checks++;
    assert (got_n === exp_n) else begin
      errors++;
      $error("FAIL %s (no-restore) got=%h want=%h", tag, got_n, exp_n);
    end
  endtask

  // Accept one opcode from IDLE and check the following 6 cycles.
  // poke: raise START with a different opcode/C during DEC (must be ignored).
  task automatic run_txn(input string tag, input logic [7:0] opc, input logic c, input logic poke);
    trace_t tr;
    trace_t tn;
    tr = build(opc, c, 1'b1);
    tn = build(opc, c, 1'b0);
    $display("txn %s opcode=%02h c=%0d poke=%0d", tag, opc, c, poke);
    START  = 1'b1;
    OPCODE = opc;
    C_IN   = c;
    tick();
    START  = poke;
    OPCODE = ~opc;
    C_IN   = ~c;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s[%0d]", tag, k), tr[k], tn[k]);
      tick();
      START  = 1'b0;
      OPCODE = 8'($urandom);
      C_IN   = 1'($urandom);
    end
  endtask

  initial begin
    trace_t t1;
    trace_t t2;
    RESET  = 1'b1;
    START  = 1'b0;
    OPCODE = 8'h00;
    C_IN   = 1'b0;
    tick();
    tick();
    chk("reset", '0, '0);
    tick();
    RESET = 1'b0;
    tick();
    chk("idle", '0, '0);
    tick();

    // Directed cases
    run_txn("ADC_imm", 8'h69, 1'b0, 1'b0);
    run_txn("CMP_imm", 8'hC9, 1'b1, 1'b0);
    run_txn("INC_zp_c0", 8'hE6, 1'b0, 1'b0);
    run_txn("LSR_A", 8'h4A, 1'b0, 1'b0);
    run_txn("DEC_zp_c1", 8'hC6, 1'b1, 1'b0);
    run_txn("LDA_imm", 8'hA9, 1'b0, 1'b0);
    run_txn("STA_imm", 8'h89, 1'b1, 1'b0);
    run_txn("CLC", 8'h18, 1'b1, 1'b0);
    run_txn("SEC", 8'h38, 1'b0, 1'b0);
    run_txn("CLV", 8'hB8, 1'b0, 1'b0);
    run_txn("ASL_A", 8'h0A, 1'b1, 1'b0);
    run_txn("bad_shift_bbb0", 8'h02, 1'b0, 1'b0);
    run_txn("NOP_EA", 8'hEA, 1'b0, 1'b0);
    run_txn("ROR_absx", 8'h7E, 1'b1, 1'b0);
    run_txn("SBC_absy", 8'hF9, 1'b0, 1'b0);
    run_txn("INC_absx_busy_poke", 8'hFE, 1'b1, 1'b1);

    // Back-to-back: START during ADC's FIN cycle starts CMP immediately.
    t1 = build(8'h69, 1'b0, 1'b1);
    t2 = build(8'hC9, 1'b0, 1'b1);
    $display("txn b2b ADC->CMP");
    START  = 1'b1;
    OPCODE = 8'h69;
    C_IN   = 1'b0;
    tick();
    START = 1'b0;
    chk("b2b_dec", t1[0], t1[0]);
    tick();
    chk("b2b_adc", t1[1], t1[1]);
    tick();
    START  = 1'b1;
    OPCODE = 8'hC9;
    chk("b2b_fin", t1[2], t1[2]);
    tick();
    START = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b2b_cmp[%0d]", k), t2[k], t2[k]);
      tick();
    end

    // Reset during INC step 2: outputs clear on the next cycle, no restore.
    t1 = build(8'hE6, 1'b0, 1'b1);
    $display("txn reset_mid_INC");
    START  = 1'b1;
    OPCODE = 8'hE6;
    C_IN   = 1'b0;
    tick();
    START = 1'b0;
    chk("rst_dec", t1[0], t1[0]);
    tick();
    chk("rst_step1", t1[1], t1[1]);
    tick();
    RESET = 1'b1;
    chk("rst_step2", t1[2], t1[2]);
    tick();
    RESET = 1'b0;
    chk("rst_after", '0, '0);
    tick();
    chk("rst_idle", '0, '0);
    tick();

    // Randomized opcodes / carry / busy pokes
    for (int i = 0; i < 150; i++) begin
      run_txn($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
